dram_axi_bridge: RTL
====================

# dram_axi_bridge

Master-side bridge that converts the CPU's single-word DRAM request interface into single-beat AXI4 transactions on the 128-bit bus of the MIG block. Sits directly upstream of the MIG AXI slave, in the same clock domain as that slave's AXI clock. Allows one outstanding transaction, with no bursts and no reordering. Handles byte-lane steering for 32-bit words within 128-bit beats.

## Interface
- No parameters. All AXI attribute constants come from the shared package.
- clk  in  1  clock; the same clock that drives the MIG block's AXI clock input
- rst  in  1  reset, synchronous, active-high
- dram_oe  in  1  request strobe; sampled only when dram_busy=0
- dram_addr  in  32  byte address; bits [1:0] are ignored
- dram_wdata  in  32  write word
- dram_we  in  4  byte enables; nonzero means write, zero means read
- dram_rdata  out  32  read word; valid while dram_valid=1, held afterwards
- dram_valid  out  1  one-cycle pulse per completed read
- dram_busy  out  1  transaction in flight; requests are ignored while high
- dram_err  out  1  sticky flag; set by a nonzero bresp/rresp, cleared only by rst
- m_axi_aw{addr 32, burst 2, cache 4, id 1, len 8, lock 1, prot 3, qos 4, region 4, size 3, valid 1}  out; m_axi_awready in 1
- m_axi_w{data 128, strb 16, last 1, valid 1}  out; m_axi_wready in 1
- m_axi_b{id 1, resp 2, valid 1} in; m_axi_bready out 1
- m_axi_ar{addr 32, burst 2, cache 4, id 1, len 8, lock 1, prot 3, qos 4, region 4, size 3, valid 1}  out; m_axi_arready in 1
- m_axi_r{data 128, id 1, last 1, resp 2, valid 1} in; m_axi_rready out 1

## Operation
- States: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE with dram_oe=1:
  - Latch addr, lane = addr[3:2], wdata and we.
  - we≠0 → WADDR; we=0 → RADDR.
- WADDR:
  - awvalid and wvalid are asserted together.
  - Each valid drops independently on its own handshake (tracked by aw_done/w_done flags).
  - When both are done → WRESP.
- WRESP: bready=1; on bvalid → IDLE; bresp≠0 sets dram_err.
- RADDR: arvalid=1 until arready → RDATA.
- RDATA:
  - rready=1; on rvalid, capture rdata[32*lane +: 32] into dram_rdata.
  - Pulse dram_valid next cycle and go to IDLE.
  - rresp≠0 sets dram_err; data is still delivered.
- Fixed AXI fields:
  - Address = {addr[31:2],2'b00}; len=0, size=3'b010, burst=INCR.
  - cache=4'b0011; prot, qos, region, lock and id are all 0.
  - wlast=1.
- Write lane steering:
  - wdata = the 32-bit word replicated ×4.
  - wstrb = we << (4*lane); all other strobe bits are 0.
- AXI stability: address, data and strobe registers stay constant while the corresponding valid is high.
- Ignored inputs: bid, rid and rlast; single ID, single beat.

## Timing
- Reset values: all valids 0, bready 0, rready 0, dram_valid 0, dram_busy 0, dram_err 0, dram_rdata 0, state IDLE.
- dram_busy = (state≠IDLE), registered.
- A request accepted at edge N shows busy=1 and the relevant valid(s) in cycle N+1.
- Read latency: dram_valid rises in the cycle after the R handshake, and busy drops in that same cycle. A new request may be sampled in that cycle.
- Write completion: busy drops in the cycle after the B handshake. The bridge produces no write acknowledge pulse.
- Handshake ordering:
  - awready and wready may arrive in any order or in the same cycle.
  - bvalid arriving before both handshakes complete is not expected; it is ignored until WRESP.
- dram_oe while busy is dropped silently; the caller must re-issue.
- rst asserted mid-transaction:
  - All valids and readies deassert on the next edge and state returns to IDLE.
  - The slave must be reset in the same cycle.

## Structure
- Package dram_axi_pkg holds:
  - the state encoding;
  - AXI constants AXI_BURST_INCR, AXI_SIZE_4B, AXI_CACHE_DEF and AXI_RESP_OKAY;
  - the data/strobe widths 128 and 16.
- Single module with no sub-module. Lane steering is a few lines of logic inside the bridge.

## Test plan
- Write addr=0x0000_0014, wdata=0xDEADBEEF, we=4'hF → awaddr=0x14, wstrb=16'h00F0, wdata lane1=0xDEADBEEF. Then read 0x14 → dram_rdata=0xDEADBEEF with a single dram_valid pulse.
- Byte write addr=0x0000_000C, we=4'b0010 → wstrb=16'h2000. Read back shows only byte 1 of lane 3 changed.
- Slave gives wready 3 cycles before awready:
  - wvalid drops after its own handshake while awvalid stays high.
  - Exactly one B handshake follows; busy lasts until the cycle after bvalid.
- dram_oe held high for 5 cycles during a read → exactly one AR issued; the extra requests are ignored.
- Slave returns rresp=2'b10 → dram_err=1 and stays set across later OKAY transactions until rst.
- rst pulsed while in RDATA with rvalid not yet seen → next cycle rready=0, busy=0, and no dram_valid pulse.

Source files
------------

// File: rtl/dram_axi_pkg.sv
// Shared constants and state encoding for the CPU-to-MIG AXI4 bridge.
package dram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int AXI_DATA_W = 128;
  localparam int AXI_STRB_W = 16;
  localparam int WORD_W     = 32;
  localparam int NUM_LANES  = AXI_DATA_W / WORD_W;

endpackage

// File: rtl/dram_axi_bridge.sv
// Single-outstanding, single-beat bridge from the CPU word interface to the
// MIG 128-bit AXI4 slave, steering the 32-bit word into its lane.
module dram_axi_bridge
  import dram_axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dram_oe,
  input  logic [31:0]           dram_addr,
  input  logic [31:0]           dram_wdata,
  input  logic [3:0]            dram_we,
  output logic [31:0]           dram_rdata,
  output logic                  dram_valid,
  output logic                  dram_busy,
  output logic                  dram_err,
  output logic [31:0]           m_axi_awaddr,
  output logic [1:0]            m_axi_awburst,
  output logic [3:0]            m_axi_awcache,
  output logic [0:0]            m_axi_awid,
  output logic [7:0]            m_axi_awlen,
  output logic                  m_axi_awlock,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [AXI_DATA_W-1:0] m_axi_wdata,
  output logic [AXI_STRB_W-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [0:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [0:0]            m_axi_arid,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arlock,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic [2:0]            m_axi_arsize,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [0:0]            m_axi_rid,
  input  logic                  m_axi_rlast,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_t      state;
  logic [31:2] addr_q;
  logic [1:0]  lane;
  logic [31:0] wdata_q;
  logic [3:0]  we_q;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs, ar_hs;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;

  // Every AXI payload field comes straight from a register that only
  // changes in IDLE, so it is stable for the whole time its valid is high.
  assign m_axi_awaddr   = {addr_q, 2'b00};
  assign m_axi_awburst  = AXI_BURST_INCR;
  assign m_axi_awcache  = AXI_CACHE_DEF;
  assign m_axi_awid     = '0;
  assign m_axi_awlen    = '0;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awprot   = '0;
  assign m_axi_awqos    = '0;
  assign m_axi_awregion = '0;
  assign m_axi_awsize   = AXI_SIZE_4B;
  assign m_axi_wlast    = 1'b1;

  assign m_axi_araddr   = {addr_q, 2'b00};
  assign m_axi_arburst  = AXI_BURST_INCR;
  assign m_axi_arcache  = AXI_CACHE_DEF;
  assign m_axi_arid     = '0;
  assign m_axi_arlen    = '0;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arprot   = '0;
  assign m_axi_arqos    = '0;
  assign m_axi_arregion = '0;
  assign m_axi_arsize   = AXI_SIZE_4B;

  // Word replicated across all lanes; only the addressed lane gets strobes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign m_axi_wdata[WORD_W*i +: WORD_W] = wdata_q;
    assign m_axi_wstrb[4*i +: 4]           = (lane == 2'(i)) ? we_q : 4'b0000;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, m_axi_bid, m_axi_rid, m_axi_rlast, dram_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      lane          <= '0;
      wdata_q       <= '0;
      we_q          <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      dram_rdata    <= '0;
      dram_valid    <= 1'b0;
      dram_busy     <= 1'b0;
      dram_err      <= 1'b0;
    end else begin
      dram_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dram_oe) begin
            addr_q    <= dram_addr[31:2];
            lane      <= dram_addr[3:2];
            wdata_q   <= dram_wdata;
            we_q      <= dram_we;
            dram_busy <= 1'b1;
            if (|dram_we) begin
              state         <= ST_WADDR;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
            end else begin
              state         <= ST_RADDR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        ST_WADDR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state        <= ST_WRESP;
            m_axi_bready <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            dram_busy    <= 1'b0;
            state        <= ST_IDLE;
            if (m_axi_bresp != AXI_RESP_OKAY) dram_err <= 1'b1;
          end
        end
        ST_RADDR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            dram_rdata   <= m_axi_rdata[WORD_W*lane +: WORD_W];
            dram_valid   <= 1'b1;
            dram_busy    <= 1'b0;
            state        <= ST_IDLE;
            if (m_axi_rresp != AXI_RESP_OKAY) dram_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
